mul_add_seq: RTL and testbench
==============================

# mul_add_seq

Sequential shift-add multiply-accumulate unit computing P = A*B + C on 16-bit unsigned operands, producing a 32-bit result in 16 iterations. It is the inverse companion of the 16-bit restoring divider. Feeding it quotient Q, divisor D and remainder R reconstructs the dividend N, so the pair supports round-trip checks. It also serves as the general multiply path. It exchanges data with the host through a start/busy/done handshake.

## Interface
- No parameters; operand width fixed at 16, result width 32.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- A  input  16  multiplicand (e.g. quotient Q)
- B  input  16  multiplier (e.g. divisor D)
- C  input  16  addend (e.g. remainder R), zero-extended
- P  output  32  result A*B + C; valid while done=1 and held until next accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse, result valid

## Operation
- States:
  - IDLE: after reset.
  - RUN: 16 iterations.
  - DONE: a single cycle.
- IDLE / DONE with start=1:
  - latch A into a 32-bit shifting multiplicand register (upper 16 bits zero).
  - latch B into a 16-bit multiplier shift register.
  - set accumulator = {16'h0, C} and iteration counter = 0.
  - go to RUN.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN, each cycle:
  - if multiplier LSB = 1: accumulator += multiplicand register (32-bit add).
  - shift the multiplicand register left by 1 and the multiplier register right by 1; counter += 1.
  - after the iteration with counter = 15: go to DONE.
- No early termination; every operation takes exactly 16 RUN cycles, including B = 0.
- start is ignored in RUN; operands A/B/C may change freely after acceptance.
- Arithmetic is unsigned. The maximum result is (2^16-1)^2 + (2^16-1) = 0xFFFF0000, so there is never overflow and no carry is lost.
- P is driven directly from the accumulator. It is only guaranteed correct when done=1 and until the next accepted start; during RUN it shows partial sums.

## Timing
- Reset: rst=1 at a rising edge gives state IDLE, P=0, busy=0, done=0, counter=0, all operand registers 0.
- rst has priority over start at every state, including mid-RUN; the operation is discarded and done does not pulse.
- busy and done are registered.
- start accepted at edge t0:
  - busy=1 from after t0 through edge t0+16.
  - done=1 and busy=0 for the cycle after edge t0+16.
  - latency is 16 cycles from acceptance to done.
- Back-to-back: start=1 during the DONE cycle is accepted at edge t0+17. busy rises again immediately with no IDLE gap, giving a throughput of 1 result per 17 cycles.
- busy and done are never high together.

## Test plan
- Reset behaviour: assert rst for 2 cycles with start=1 -> P=0, busy=0, done=0; no operation starts.
- Basic: A=0x1234, B=0x0056, C=0x0012 -> done pulses exactly 16 cycles after the start edge with P=0x00061D8A; busy high for exactly 16 cycles.
- Extremes:
  - A=B=C=0xFFFF -> P=0xFFFF0000.
  - A=0x0000, B=0xBEEF, C=0x00AB -> P=0x000000AB.
  - B=0 -> P=C, still 16-cycle latency.
- Divider round trip: Q=142, D=7, R=6 (from N=1000) -> P=0x000003E8. Also Q=0, D=0x00FF, R=0x0010 -> P=0x00000010.
- Handshake: pulse start mid-RUN with different operands -> ignored, original result delivered. Assert start during the DONE cycle with A=2, B=3, C=1 -> busy next cycle, second done 17 cycles after the first with P=0x00000007. Changing A/B/C during RUN does not affect the result.
- Reset mid-operation: assert rst at RUN iteration 8 -> next cycle IDLE, P=0, busy=0, no done pulse. A new start then completes normally.

Source files
------------

// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-add multiply-accumulate, P = A*B + C.
// 16-bit unsigned operands and a 32-bit result, produced over 16 iterations.
// It is the companion of the 16-bit restoring divider: Q*D + R rebuilds N.
// The host uses a start/busy/done handshake. P holds the accumulator, so it
// is only meaningful while done=1 and until the next accepted start.
module mul_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  output logic [31:0] P,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] mcand;   // multiplicand, shifted left once per iteration
  logic [15:0] mplr;    // multiplier, shifted right once per iteration
  logic [31:0] acc;     // running sum, seeded with the zero-extended addend
  logic [3:0]  cnt;     // iteration index, 0..15
  logic        accept;  // start taken this cycle
  logic        last;    // this RUN cycle is the final iteration

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == 4'd15);
  assign P      = acc;

  // Next-state logic: start is only looked at in IDLE or DONE.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves state_next
    // unassigned; a missing path would infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last)   state_next = DONE;
      DONE: state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered busy/done flags derived from next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs at the same edge, independent of statement order.
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: load operands on accept, then one conditional add and shift per
  // RUN cycle. Reset clears everything so P reads zero and an operation in
  // flight is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= {16'h0000, A};
      mplr  <= B;
      acc   <= {16'h0000, C};
      cnt   <= '0;
    end else if (state == RUN) begin
      // The largest possible sum is 0xFFFF0000, so the 32-bit add never
      // carries out.
      if (mplr[0]) begin
        acc <= acc + mcand;
      end
      mcand <= {mcand[30:0], 1'b0};
      mplr  <= {1'b0, mplr[15:1]};
      cnt   <= cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// Testbench for mul_add_seq: directed vectors from a table, handshake and
// reset corner sequences, and random operands against an arithmetic model.
module tb_mul_add_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic [31:0] P;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mul_add_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [31:0] p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [15:0] c);
    return 32'(a) * 32'(b) + 32'(c);
  endfunction

  // Present operands with start for one edge; returns #1 after that edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c);
    @(negedge clk);
    A = a; B = b; C = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge. Counts edges until done (bounded),
  // counting busy samples along the way. With disturb set, operands are
  // scrambled every cycle and start is pulsed once mid-RUN.
  task automatic wait_done(input string name, input bit disturb,
                           output int lat, output int bcnt);
    int overlap;
    lat     = 0;
    overlap = 0;
    bcnt    = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (disturb) begin
        A = 16'($urandom); B = 16'($urandom); C = 16'($urandom);
        start = (lat == 5);
      end
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
      if (busy && done) overlap++;
    end
    start = 1'b0;
    check({name, " latency"}, 32'(lat), 32'd16);
    check({name, " busy cycles"}, 32'(bcnt), 32'd16);
    check({name, " busy&done overlap"}, 32'(overlap), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c,
                        input logic [31:0] exp, input bit disturb);
    int lat, bcnt;
    launch(a, b, c);
    wait_done(name, disturb, lat, bcnt);
    check({name, " P"}, P, exp);
  endtask

  vec_t vecs[6];

  initial begin
    int lat, bcnt, seen;
    logic [15:0] ra, rb, rc;

    vecs[0] = '{16'h1234, 16'h0056, 16'h0012, 32'h00061D8A};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000};
    vecs[2] = '{16'h0000, 16'hBEEF, 16'h00AB, 32'h000000AB};
    vecs[3] = '{16'h9ABC, 16'h0000, 16'h4321, 32'h00004321};
    vecs[4] = '{16'd142,  16'd7,    16'd6,    32'h000003E8};
    vecs[5] = '{16'h0000, 16'h00FF, 16'h0010, 32'h00000010};

    rst = 1'b1; start = 1'b1; A = 16'h1111; B = 16'h2222; C = 16'h3333;

    // Reset held two cycles with start high: nothing may start.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset P", P, 32'h0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset idle busy", 32'(busy), 32'd0);
    check("post-reset idle P", P, 32'h0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
             vecs[i].p, 1'b0);
      @(negedge clk);
    end

    // Mid-RUN start and operand changes must not affect the result.
    run_op("ignore mid-run", 16'hA5A5, 16'h5A5A, 16'h0F0F,
           model(16'hA5A5, 16'h5A5A, 16'h0F0F), 1'b1);
    check("done is one pulse", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    check("done pulse ends", 32'(done), 32'd0);

    // Back-to-back: start during the DONE cycle.
    run_op("b2b first", 16'h0100, 16'h0100, 16'h0001, 32'h00010001, 1'b0);
    launch(16'd2, 16'd3, 16'd1);
    check("b2b busy after accept", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    wait_done("b2b second", 1'b0, lat, bcnt);
    check("b2b second P", P, 32'h00000007);

    // Reset at RUN iteration 8 discards the operation.
    @(negedge clk);
    launch(16'h4444, 16'h5555, 16'h6666);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid reset P", P, 32'h0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("no activity after mid reset", 32'(seen), 32'd0);
    run_op("after mid reset", 16'h0BAD, 16'hCAFE, 16'h0042,
           model(16'h0BAD, 16'hCAFE, 16'h0042), 1'b0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      if (i == 0) rb = 16'h0000;
      if (i == 1) ra = 16'hFFFF;
      run_op($sformatf("rand%0d", i), ra, rb, rc, model(ra, rb, rc),
             (i % 3) == 0);
      if ((i % 2) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
